regfile_read_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32x64 register-file read port among N_REQ requesters (fetch/decode, store-data path, debug, and similar).
- Drives the select of the external 32:1 read mux and captures the mux output in a response register.
- Forwards same-cycle write-port data to the reader.
- Returns the read value to the winning requester one cycle after grant.
- Sits between the register array/read mux and the pipeline stages that need an extra read port.

---
 rtl/regfile_read_arbiter.sv | 98 +++++++++
 tb/tb_regfile_read_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among N_REQ requesters.
// Write-first forwarding, zero-register handling, and a registered response one cycle after grant.
module regfile_read_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 64,
    parameter int AW       = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*AW-1:0] req_addr_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [AW-1:0]       rd_sel_o,
    input  logic [DW-1:0]       rd_data_i,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [DW-1:0]       wr_data_i,
    output logic [N_REQ-1:0]    resp_valid_o,
    output logic [DW-1:0]       resp_data_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DW-1:0]    resp_data_q, resp_data_d;
    logic [AW-1:0]    addr_arr [N_REQ];
    logic             found;
    logic [PW-1:0]    winner;

    always_comb begin : unpack_addr
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i] = req_addr_i[i*AW +: AW];
        end
    end

    // Scan from the pointer, wrapping; reset masks any grant.
    always_comb begin : arbitrate
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
        if (reset_i) begin
            found = 1'b0;
        end
    end

    always_comb begin : grant_out
        for (int i = 0; i < N_REQ; i++) begin
            gnt_o[i] = found && (winner == PW'(i));
        end
        rd_sel_o = found ? addr_arr[winner] : '0;
    end

    // Zero register beats forwarding; forwarding beats the array read.
    always_comb begin : next_state
        resp_data_d  = resp_data_q;
        resp_valid_d = gnt_o;
        ptr_d        = ptr_q;
        if (found) begin
            if (rd_sel_o == AW'(ZERO_REG)) begin
                resp_data_d = '0;
            end else if (wr_en_i && (wr_addr_i == rd_sel_o)) begin
                resp_data_d = wr_data_i;
            end else begin
                resp_data_d = rd_data_i;
            end
            ptr_d = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: a round-robin reference model predicts grants
// and response data; a separate monitor pops expectations when responses are due.
module tb_regfile_read_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rd_sel;
    logic [DW-1:0]   rd_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;

    logic [DW-1:0]   mem [32];

    always #5 clk = ~clk;
    assign rd_data = mem[rd_sel];

    regfile_read_arbiter #(.N_REQ(N), .DW(DW), .AW(AW), .ZERO_REG(31)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_addr_i(req_addr),
        .gnt_o(gnt), .rd_sel_o(rd_sel), .rd_data_i(rd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data)
    );

    typedef struct {
        int          due;
        logic [N-1:0] vld;
        logic [DW-1:0] data;
        logic         chkd;
        logic [DW-1:0] cdata;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_seen = 1'b0;
    int   m_ptr = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N*AW-1:0] a,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input int want_g, input logic want_den, input logic [DW-1:0] want_d,
                        output int won);
        int            w;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        exp_t          e;
        @(posedge clk);
        #1;
        reset = rst; req = r; req_addr = a; wr_en = we; wr_addr = wa; wr_data = wd;
        #2;
        w = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && r[i]) w = i;
            end
        end
        eg = '0;
        ea = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ea = a[w*AW +: AW];
        end
        chk("gnt", DW'(gnt), DW'(eg));
        chk("rd_sel", DW'(rd_sel), DW'(ea));
        if (want_g >= 0) chk("gnt_directed", DW'(gnt), DW'(want_g));
        if (rst) begin
            m_ptr = 0;
        end else if (w >= 0) begin
            e.due   = cyc + 1;
            e.vld   = eg;
            e.data  = (ea == 5'd31) ? '0 : ((we && wa == ea) ? wd : mem[ea]);
            e.chkd  = want_den;
            e.cdata = want_d;
            sbq.push_back(e);
            m_ptr = (w + 1) % N;
        end
        won = w;
    endtask

    initial begin : monitor
        exp_t          e;
        logic [DW-1:0] last;
        last = '0;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                chk("resp_missed", DW'(1), DW'(0));
            end
            if (rst_seen) begin
                chk("rst_resp_valid", DW'(resp_valid), '0);
                chk("rst_resp_data", resp_data, '0);
                last = '0;
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("resp_valid", DW'(resp_valid), DW'(e.vld));
                chk("resp_data", resp_data, e.data);
                if (e.chkd) chk("resp_data_directed", resp_data, e.cdata);
                last = e.data;
            end else begin
                chk("idle_resp_valid", DW'(resp_valid), '0);
                chk("idle_resp_hold", resp_data, last);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int            won;
        int            gs [5];
        logic [N-1:0]  r;
        logic [N*AW-1:0] a;
        reset = 1'b1; req = '0; req_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) mem[i] = 64'h100 + DW'(i);
        mem[5]  = 64'hAAAA;
        mem[7]  = 64'h1234;
        mem[31] = 64'hFFFF;
        gs = '{1, 2, 4, 8, 1};

        for (int i = 0; i < 3; i++) step(1'b1, '0, '0, 1'b0, '0, '0, 0, 1'b0, '0, won);
        step(1'b0, 4'b0001, pk(5, 0, 0, 0), 1'b0, '0, '0, 1, 1'b1, 64'hAAAA, won);
        step(1'b0, 4'b0000, '0, 1'b0, '0, '0, 0, 1'b0, '0, won);

        step(1'b1, '0, '0, 1'b0, '0, '0, 0, 1'b0, '0, won);
        for (int i = 0; i < 5; i++)
            step(1'b0, 4'b1111, pk(1, 2, 3, 4), 1'b0, '0, '0, gs[i], 1'b1, 64'h101 + DW'(gs[i] == 1 ? 0 : (gs[i] == 2 ? 1 : (gs[i] == 4 ? 2 : 3))), won);

        step(1'b0, 4'b0010, pk(0, 9, 0, 0), 1'b0, '0, '0, 2, 1'b1, 64'h109, won);
        step(1'b0, 4'b0011, pk(0, 9, 0, 0), 1'b0, '0, '0, 1, 1'b1, 64'h100, won);
        step(1'b0, 4'b0011, pk(0, 9, 0, 0), 1'b0, '0, '0, 2, 1'b1, 64'h109, won);

        step(1'b0, 4'b0001, pk(7, 0, 0, 0), 1'b1, 5'd7, 64'hDEAD, 1, 1'b1, 64'hDEAD, won);
        step(1'b0, 4'b0001, pk(7, 0, 0, 0), 1'b1, 5'd8, 64'hDEAD, 1, 1'b1, 64'h1234, won);
        step(1'b0, 4'b0010, pk(0, 31, 0, 0), 1'b1, 5'd31, 64'h5, 2, 1'b1, 64'h0, won);

        step(1'b0, 4'b0100, pk(0, 0, 6, 0), 1'b0, '0, '0, 4, 1'b1, 64'h106, won);
        step(1'b1, 4'b1111, pk(1, 2, 3, 4), 1'b0, '0, '0, 0, 1'b0, '0, won);
        step(1'b0, 4'b1111, pk(1, 2, 3, 4), 1'b0, '0, '0, 1, 1'b1, 64'h101, won);
        step(1'b0, 4'b0000, '0, 1'b0, '0, '0, 0, 1'b0, '0, won);

        r = '0;
        a = '0;
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        for (int c = 0; c < 400; c++) begin
            logic          we;
            logic [AW-1:0] wa;
            for (int i = 0; i < N; i++) begin
                if (!r[i] && $urandom_range(0, 2) == 0) begin
                    r[i] = 1'b1;
                    a[i*AW +: AW] = AW'($urandom_range(0, 31));
                end else if (r[i] && $urandom_range(0, 15) == 0) begin
                    r[i] = 1'b0;
                end
            end
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 2) == 0) ? a[$urandom_range(0, N-1)*AW +: AW] : AW'($urandom_range(0, 31));
            step(c % 97 == 96 ? 1'b1 : 1'b0, r, a, we, wa, {$urandom, $urandom}, -1, 1'b0, '0, won);
            if (won >= 0) r[won] = ($urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 0, 1'b0, '0, won);
        chk("scoreboard_drained", DW'(sbq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
